// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: fetch-stage PC generator and decoupling instruction queue.
//
// The fetch PC is shown to an external branch predictor (bp_pc) and to
// instruction memory (imem_req_addr). Each accepted request records
// {pc, pred_pc, ghr} in an in-flight metadata FIFO. Responses return in order.
// Each response is paired with its metadata and pushed into the fetch queue that
// feeds decode. A redirect from Execute clears both FIFOs and drops the
// responses that are still outstanding.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req_*               request valid/ready/address toward instruction memory
//   imem_rsp_*               in-order response valid and instruction word
//   bp_pc / bp_*             PC presented to the predictor, and its prediction
//   redirect_valid/_pc       flush and restart from Execute
//   if_*                     queue head toward decode (valid/ready handshake)
//   fq_count                 current fetch-queue occupancy
//
// Optional feature macro: FETCH_BYPASS_EN. When it is defined, a response that
// arrives at an empty queue is shown on if_* in the same cycle.
module fetch_queue_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     FQ_DEPTH = 4,
  parameter int unsigned     MAX_OUT  = 2,
  parameter int unsigned     GHR_W    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req_valid,
  input  logic                        imem_req_ready,
  output logic [XLEN-1:0]             imem_req_addr,
  input  logic                        imem_rsp_valid,
  input  logic [31:0]                 imem_rsp_data,
  output logic [XLEN-1:0]             bp_pc,
  input  logic                        bp_taken,
  input  logic [XLEN-1:0]             bp_target,
  input  logic [GHR_W-1:0]            bp_ghr,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  output logic                        if_valid,
  input  logic                        if_ready,
  output logic [XLEN-1:0]             if_pc,
  output logic [31:0]                 if_instr,
  output logic [XLEN-1:0]             if_pred_pc,
  output logic [GHR_W-1:0]            if_ghr,
  output logic [$clog2(FQ_DEPTH):0]   fq_count
);

  localparam int unsigned CW  = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned QAW = $clog2(FQ_DEPTH);
  localparam int unsigned MAW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   out_q, out_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [MAW-1:0]  m_wr_q, m_wr_d, m_rd_q, m_rd_d;
  logic [QAW-1:0]  q_wr_q, q_wr_d, q_rd_q, q_rd_d;

  logic [XLEN-1:0]  m_pc_mem   [MAX_OUT];
  logic [XLEN-1:0]  m_pred_mem [MAX_OUT];
  logic [GHR_W-1:0] m_ghr_mem  [MAX_OUT];
  logic [XLEN-1:0]  q_pc_mem    [FQ_DEPTH];
  logic [31:0]      q_instr_mem [FQ_DEPTH];
  logic [XLEN-1:0]  q_pred_mem  [FQ_DEPTH];
  logic [GHR_W-1:0] q_ghr_mem   [FQ_DEPTH];

  logic [CW:0]     credit_sum;
  logic            req_fire, rsp_drop, rsp_keep, bypass, push_q, pop_q, q_empty;
  logic [XLEN-1:0] pred_pc;

  // The metadata FIFO depth need not be a power of two, so wrap explicitly.
  function automatic logic [MAW-1:0] m_inc(input logic [MAW-1:0] p);
    return (p == MAW'(MAX_OUT - 1)) ? '0 : p + MAW'(1);
  endfunction

  // Outstanding + queued never exceeds FQ_DEPTH, so a response always finds a slot.
  assign credit_sum     = {1'b0, out_q} + {1'b0, cnt_q};
  assign imem_req_valid = !rst && !redirect_valid && (out_q < CW'(MAX_OUT)) &&
                          (credit_sum < (CW + 1)'(FQ_DEPTH));
  assign imem_req_addr  = pc_q;
  assign bp_pc          = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign pred_pc        = bp_taken ? bp_target : pc_q + XLEN'(4);

  assign rsp_drop = (drop_q != '0);
  assign rsp_keep = imem_rsp_valid && !rsp_drop && !redirect_valid;
  assign q_empty  = (cnt_q == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_keep && q_empty;
`else
  assign bypass = 1'b0;
`endif

  assign if_valid = !q_empty || bypass;
  assign pop_q    = if_ready && !q_empty;
  // A bypassed response that decode takes this cycle is never written.
  assign push_q   = rsp_keep && !(bypass && if_ready);
  assign fq_count = cnt_q;

  always_comb begin
    if_pc      = q_pc_mem[q_rd_q];
    if_instr   = q_instr_mem[q_rd_q];
    if_pred_pc = q_pred_mem[q_rd_q];
    if_ghr     = q_ghr_mem[q_rd_q];
    if (bypass) begin
      if_pc      = m_pc_mem[m_rd_q];
      if_instr   = imem_rsp_data;
      if_pred_pc = m_pred_mem[m_rd_q];
      if_ghr     = m_ghr_mem[m_rd_q];
    end
  end

  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_d = drop_q;
    m_wr_d = m_wr_q;
    m_rd_d = m_rd_q;
    q_wr_d = q_wr_q;
    q_rd_d = q_rd_q;
    cnt_d  = cnt_q + CW'(push_q) - CW'(pop_q);
    if (req_fire) begin
      pc_d   = pred_pc;
      m_wr_d = m_inc(m_wr_q);
    end
    if (imem_rsp_valid && rsp_drop) drop_d = drop_q - CW'(1);
    if (rsp_keep) m_rd_d = m_inc(m_rd_q);
    if (push_q)   q_wr_d = q_wr_q + QAW'(1);
    if (pop_q)    q_rd_d = q_rd_q + QAW'(1);
    if (redirect_valid) begin
      pc_d   = redirect_pc & ~XLEN'(3);
      // Every request still in flight is stale; this replaces any old count.
      drop_d = out_q - CW'(imem_rsp_valid);
      m_wr_d = '0;
      m_rd_d = '0;
      q_wr_d = '0;
      q_rd_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
      m_wr_q <= '0;
      m_rd_q <= '0;
      q_wr_q <= '0;
      q_rd_q <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      m_wr_q <= m_wr_d;
      m_rd_q <= m_rd_d;
      q_wr_q <= q_wr_d;
      q_rd_q <= q_rd_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage arrays carry no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      m_pc_mem[m_wr_q]   <= pc_q;
      m_pred_mem[m_wr_q] <= pred_pc;
      m_ghr_mem[m_wr_q]  <= bp_ghr;
    end
    if (push_q) begin
      q_pc_mem[q_wr_q]    <= m_pc_mem[m_rd_q];
      q_instr_mem[q_wr_q] <= imem_rsp_data;
      q_pred_mem[q_wr_q]  <= m_pred_mem[m_rd_q];
      q_ghr_mem[q_wr_q]   <= m_ghr_mem[m_rd_q];
    end
  end

endmodule
